// File: rtl/word_serializer.sv
// word_serializer: parallel-to-serial front end for the sequence detector.
// Ports: clk, rst (async, active-high); in_data/in_valid/in_ready word
// handshake; x/x_valid/last serial output; busy = shifting or word held.
module word_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;

    logic             accept;
    logic             at_last;
    logic [WIDTH-1:0] sh_next;

    assign accept  = in_valid & ~hold_full_q;
    assign at_last = (cnt_q == CW'(WIDTH - 1));
    assign sh_next = MSB_FIRST ? (sh_q << 1) : (sh_q >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    sh_d        = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = SHIFT;
                end else if (accept) begin
                    sh_d    = in_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (at_last) begin
                    cnt_d = '0;
                    if (hold_full_q) begin
                        sh_d        = hold_q;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        sh_d = in_data;
                    end else begin
                        // Clearing the shifter keeps x at 0 while idle.
                        sh_d    = '0;
                        state_d = IDLE;
                    end
                end else begin
                    sh_d  = sh_next;
                    cnt_d = cnt_q + CW'(1);
                    if (accept) begin
                        hold_d      = in_data;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready = ~hold_full_q;
    assign x        = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
    assign x_valid  = (state_q == SHIFT);
    assign last     = (state_q == SHIFT) & at_last;
    assign busy     = (state_q == SHIFT) | hold_full_q;

endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: randomized and directed checks of word_serializer
// against a bit-queue reference model; also a WIDTH=4 LSB-first instance.
module tb_word_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, x, x_valid, last, busy;

    logic [3:0] in4_data = 4'h0;
    logic       in4_valid = 1'b0;
    logic       in4_ready, x4, xv4, last4, busy4;

    int checks = 0;
    int errors = 0;

    // Expected serial stream: each entry is {last, bit}.
    bit [1:0]   q[$];
    bit         obs[$];
    logic [7:0] wq[$];

    word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .x(x), .x_valid(x_valid), .last(last),
        .busy(busy)
    );

    word_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut4 (
        .clk(clk), .rst(rst), .in_data(in4_data), .in_valid(in4_valid),
        .in_ready(in4_ready), .x(x4), .x_valid(xv4), .last(last4),
        .busy(busy4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    // One clock: check outputs against the model, drive inputs, then
    // append the bits of an accepted word to the expected stream.
    task automatic cycle(input bit v, input logic [7:0] d, output bit acc);
        int       len;
        bit [1:0] e;
        @(negedge clk);
        len = q.size();
        e   = (len > 0) ? q[0] : 2'b00;
        check("x_valid", x_valid, 32'(len > 0));
        check("x", x, 32'(e[0]));
        check("last", last, 32'(e[1]));
        check("in_ready", in_ready, 32'(len <= 8));
        check("busy", busy, 32'(len > 0));
        if (x_valid) obs.push_back(x);
        if (len > 0) void'(q.pop_front());
        in_valid = v;
        in_data  = v ? d : 8'($urandom);
        acc      = v && (len <= 8);
        @(posedge clk);
        if (acc) begin
            for (int i = 7; i >= 0; i--) q.push_back({i == 0, d[i]});
        end
    endtask

    // Offer the words in wq back to back with in_valid held high.
    task automatic run_words();
        int idx = 0;
        bit acc;
        for (int c = 0; c < 200 && (idx < wq.size() || q.size() > 0); c++) begin
            if (idx < wq.size()) cycle(1'b1, wq[idx], acc);
            else cycle(1'b0, 8'h00, acc);
            if (acc) idx++;
        end
        check("drain", 32'(idx + q.size()), 32'(wq.size()));
        cycle(1'b0, 8'h00, acc);
        cycle(1'b0, 8'h00, acc);
    endtask

    function automatic logic [31:0] packed_obs();
        logic [31:0] s = '0;
        foreach (obs[i]) s = {s[30:0], obs[i]};
        return s;
    endfunction

    initial begin
        bit       acc;
        int       dens;
        bit [3:0] w4;

        // Reset values.
        @(negedge clk);
        check("rst_x_valid", x_valid, 0);
        check("rst_x", x, 0);
        check("rst_last", last, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single word.
        obs.delete();
        wq = {8'hB2};
        run_words();
        check("t1_len", 32'(obs.size()), 8);
        check("t1_stream", packed_obs(), 32'h0000_00B2);

        // Streaming with no gaps.
        obs.delete();
        wq = {8'hB2, 8'h0F, 8'hA5};
        run_words();
        check("t2_len", 32'(obs.size()), 24);
        check("t2_stream", packed_obs(), 32'h00B2_0FA5);

        // Back-pressure: 7E goes to hold, FF waits for the drain.
        obs.delete();
        wq = {8'h81, 8'h7E, 8'hFF};
        run_words();
        check("t3_len", 32'(obs.size()), 24);
        check("t3_stream", packed_obs(), 32'h0081_7EFF);

        // Reset mid-word with a word held.
        cycle(1'b1, 8'hB2, acc);
        cycle(1'b1, 8'h0F, acc);
        cycle(1'b0, 8'h00, acc);
        #1;
        check("t5_pre_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("t5_x_valid", x_valid, 0);
        check("t5_x", x, 0);
        check("t5_busy", busy, 0);
        check("t5_in_ready", in_ready, 1);
        q.delete();
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) cycle(1'b0, 8'h00, acc);

        // Randomized traffic with varying offer density.
        for (int n = 0; n < 1600; n++) begin
            if (n % 100 == 0) dens = $urandom_range(10, 100);
            cycle($urandom_range(0, 99) < dens, 8'($urandom), acc);
        end
        for (int c = 0; c < 40 && q.size() > 0; c++) cycle(1'b0, 8'h00, acc);
        check("rand_drain", 32'(q.size()), 0);

        // WIDTH=4, LSB first.
        w4 = 4'b0110;
        @(negedge clk);
        check("w4_ready", in4_ready, 1);
        check("w4_idle", xv4, 0);
        in4_valid = 1'b1;
        in4_data  = w4;
        @(posedge clk);
        @(negedge clk);
        in4_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("w4_valid", xv4, 1);
            check("w4_x", x4, 32'(w4[i]));
            check("w4_last", last4, 32'(i == 3));
            @(negedge clk);
        end
        check("w4_end_valid", xv4, 0);
        check("w4_end_busy", busy4, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
Parallel-to-serial front end for the sequence detector. Accepts WIDTH-bit words over a valid/ready handshake and drives them onto the detector's serial input x, one bit per clock, MSB first by default. A one-word holding register lets back-to-back words stream with no idle cycles between them.

Parameters:
WIDTH, 8, word length in bits; must be >= 2.
MSB_FIRST, 1, 1 = send bit WIDTH-1 first; 0 = send bit 0 first.

Ports:
clk  input  1  system clock; all registers update on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_data  input  WIDTH  parallel word to serialize.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  block can accept a word this cycle.
x  output  1  serial bit to the detector's x input.
x_valid  output  1  x carries a real data bit this cycle.
last  output  1  x is the final bit of the current word.
busy  output  1  shifter active or holding register occupied.

Behaviour:
- Reset is asynchronous and active-high. Clock and reset ports are named clk and rst.
- Accept: a word is transferred on a rising edge where in_valid=1 and in_ready=1.
- in_ready = ~hold_full. This is combinational from a register and has no combinational path from in_valid.
- Internal state: shifter sh[WIDTH-1:0], bit counter cnt (0..WIDTH-1), hold[WIDTH-1:0], hold_full, FSM {IDLE, SHIFT}.
- x and x_valid are driven directly from registers. x = sh[WIDTH-1] when MSB_FIRST=1, else sh[0].
- x = 0 whenever x_valid = 0.
- IDLE:
  - On accept, in_data loads into sh, cnt=0, go to SHIFT.
  - The first bit appears on x in the cycle right after the accept edge (latency 1).
  - If hold_full in IDLE (cannot occur in normal operation), load hold into sh and clear hold_full.
- SHIFT:
  - x_valid=1. Each edge shifts sh by one toward the output end and increments cnt.
  - last=1 when cnt==WIDTH-1.
- End of word (edge where cnt==WIDTH-1):
  - hold_full=1: load hold into sh, cnt=0, clear hold_full, stay in SHIFT. No bubble.
  - hold_full=0 with a simultaneous accept: load in_data directly into sh, stay in SHIFT.
  - hold_full=0 with no accept: go to IDLE. x_valid=0 on the next cycle.
- Accept in SHIFT when not at the last bit: word goes to hold and hold_full is set.
- A second word cannot be accepted until hold drains (in_ready=0).
- Ordering: words are emitted in acceptance order; no word is ever dropped or duplicated.
- busy = (state==SHIFT) | hold_full.
- Values on reset: state=IDLE, sh=0, cnt=0, hold=0, hold_full=0, x=0, x_valid=0, last=0, in_ready=1, busy=0.
- Reset mid-word: the partial word and any held word are discarded. x_valid drops immediately (asynchronously). After reset deasserts, no residual bits are emitted.
- in_data is ignored when in_valid=0 or in_ready=0.

Test Plan:
1. Reset, then a single word 8'hB2 accepted at edge N -> x = 1,0,1,1,0,0,1,0 on cycles N+1..N+8; x_valid=1 for exactly those 8 cycles; last=1 only at N+8; x_valid=0 and busy=0 at N+9.
2. in_valid held high with words 8'hB2, 8'h0F, 8'hA5 -> 24 consecutive x_valid cycles with no gap; bits match MSB-first order; last pulses every 8th cycle; in_ready=0 while hold_full.
3. Back-pressure: 8'h81 accepted, then 8'h7E offered continuously -> 8'h7E accepted into hold on the next edge; in_ready stays 0 until the edge where 8'h81's last bit is sent; output is 1,0,0,0,0,0,0,1,0,1,1,1,1,1,1,0.
4. Accept 8'h81 at edge N while not at the last bit, then offer 8'hFF at edge N+1 (in_ready=0) -> 8'hFF is not taken; it is accepted only at the edge where in_ready returns to 1.
5. rst asserted after 3 bits of 8'hB2, with 8'h0F in hold -> x_valid, x and busy go to 0 immediately; in_ready=1; after release with no input, x_valid stays 0.
6. MSB_FIRST=0, WIDTH=4, word 4'b0110 -> x = 0,1,1,0; last on the 4th bit.
